program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width (16 locations).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM word and stream byte width.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load session.
REQ-006 SHALL have port in_valid  input  1  upstream byte valid.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  upstream byte.
REQ-008 SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-009 SHALL have port ram_we  output  1  RAM write strobe, one cycle per data byte.
REQ-010 SHALL have port ram_addr  output  ADDR_WIDTH  RAM write address.
REQ-011 SHALL have port ram_wdata  output  DATA_WIDTH  RAM write data.
REQ-012 SHALL have port cpu_hold  output  1  holds the CPU in reset while high.
REQ-013 SHALL have port busy  output  1  session in progress.
REQ-014 SHALL have port done  output  1  last session loaded with good checksum.
REQ-015 SHALL have port error  output  1  last session failed (bad length or checksum).

Function
REQ-016 SHALL implement states IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-017 Stream format SHALL be: length byte N, then N data bytes, then checksum byte equal to the sum mod 256 of the N data bytes.
REQ-018 A byte SHALL transfer only on a rising edge where in_valid and in_ready are both high; in_valid without in_ready SHALL be ignored.
REQ-019 in_ready SHALL be high exactly in LEN, DATA and CSUM; low in IDLE, DONE, ERR.
REQ-020 IDLE/DONE/ERR + start SHALL go to LEN next cycle, clear done, error, address counter and checksum accumulator; start while busy SHALL be ignored.
REQ-021 LEN transfer: N in 1..2^ADDR_WIDTH SHALL latch N and go to DATA; N = 0 or N > 2^ADDR_WIDTH SHALL go to ERR.
REQ-022 DATA transfer SHALL, on the following cycle, drive ram_we high for exactly one cycle with ram_addr = byte index (0 first) and ram_wdata = the byte; accumulator adds the byte mod 256.
REQ-023 After the Nth data transfer SHALL go to CSUM; address counter SHALL NOT wrap past N-1.
REQ-024 CSUM transfer: byte equal to accumulator SHALL go to DONE with done = 1; otherwise ERR with error = 1; no RAM write in either case.
REQ-025 ram_we SHALL be 0 in every cycle other than those of REQ-022; ram_addr/ram_wdata hold last written values otherwise.
REQ-026 busy SHALL be high in LEN, DATA, CSUM only.
REQ-027 cpu_hold SHALL be high in LEN, DATA, CSUM and ERR; low in IDLE and DONE.
REQ-028 done and error SHALL never be high together and SHALL hold until the next start or reset.
REQ-029 Back-to-back transfers (in_valid held high) SHALL be accepted at one byte per cycle with no bubbles.
REQ-030 Gaps in in_valid SHALL stall the FSM in its current state with no side effects.
REQ-031 RAM contents written before an ERR SHALL remain; the loader SHALL NOT erase them.

Reset
REQ-032 reset SHALL force IDLE, in_ready = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, busy = 0, done = 0, error = 0, cpu_hold = 0 on the next rising edge.
REQ-033 reset mid-session SHALL abort with no further RAM writes, including a write pending from the prior cycle.
REQ-034 reset SHALL take priority over start and over any simultaneous transfer.

Verification
REQ-035 start; stream 03, 0E, 10, AB, C9 back-to-back -> writes 0E@0, 10@1, AB@2, then done = 1, cpu_hold = 0, error = 0.
REQ-036 start; stream 02, 11, 22, 34 -> two writes, then error = 1, cpu_hold = 1, done = 0.
REQ-037 start; length 00, then length 11 (17) in a second session -> ERR each time, no ram_we pulses.
REQ-038 start; length 10 (16), data 00..0F, checksum 78 -> addresses 0..F written, no wrap, done = 1.
REQ-039 start; 03, 0E then in_valid low 5 cycles, then 10, AB, C9 -> identical writes to REQ-035, FSM stalls in DATA during the gap.
REQ-040 reset asserted the cycle after the 2nd data byte is accepted -> no ram_we that cycle, all outputs at REQ-032 values; start pulse during busy ignored.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Receives a boot image over a valid/ready byte stream and writes it into a
//   small program RAM while holding the CPU in reset.
//   Stream: length byte N (1..2^ADDR_WIDTH), N data bytes, then one checksum
//   byte equal to the mod-2^DATA_WIDTH sum of the data bytes.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   reset      synchronous active-high reset
//   start      one-cycle pulse that opens a load session (ignored while busy)
//   in_valid   upstream byte valid
//   in_data    upstream byte
//   in_ready   loader accepts a byte this cycle (LEN, DATA, CSUM)
//   ram_we     RAM write strobe, one cycle per data byte
//   ram_addr   RAM write address (byte index within the image)
//   ram_wdata  RAM write data
//   cpu_hold   CPU held in reset (LEN, DATA, CSUM, ERR)
//   busy       session in progress (LEN, DATA, CSUM)
//   done       last session loaded with a good checksum
//   error      last session failed (bad length or checksum)
module program_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // One extra bit so a full-depth length (2^ADDR_WIDTH) is representable.
  localparam int          LEN_W   = ADDR_WIDTH + 1;
  localparam int unsigned MAX_LEN = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t                  state_r,     state_s;
  logic [LEN_W-1:0]        len_r,       len_s;
  logic [LEN_W-1:0]        cnt_r,       cnt_s;
  logic [DATA_WIDTH-1:0]   acc_r,       acc_s;
  logic                    ram_we_r,    ram_we_s;
  logic [ADDR_WIDTH-1:0]   ram_addr_r,  ram_addr_s;
  logic [DATA_WIDTH-1:0]   ram_wdata_r, ram_wdata_s;
  logic                    done_r,      done_s;
  logic                    error_r,     error_s;
  logic                    in_ready_r,  busy_r, cpu_hold_r;
  logic                    xfer_s;
  logic                    len_bad_s;
  logic                    in_session_s;

  assign xfer_s       = in_valid & in_ready_r;
  assign len_bad_s    = (in_data == {DATA_WIDTH{1'b0}}) || (32'(in_data) > MAX_LEN);
  assign in_session_s = (state_s == LEN) || (state_s == DATA) || (state_s == CSUM);

  // Next-state, datapath and output-flag computation.
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    cnt_s       = cnt_r;
    acc_s       = acc_r;
    ram_we_s    = 1'b0;
    ram_addr_s  = ram_addr_r;
    ram_wdata_s = ram_wdata_r;
    done_s      = done_r;
    error_s     = error_r;

    case (state_r)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_s = LEN;
          cnt_s   = {LEN_W{1'b0}};
          acc_s   = {DATA_WIDTH{1'b0}};
          done_s  = 1'b0;
          error_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      LEN: begin
        if (xfer_s) begin
          if (len_bad_s) begin
            state_s = ERR;
            error_s = 1'b1;
          end else begin
            state_s = DATA;
            len_s   = LEN_W'(in_data);
          end
        end else begin
          state_s = LEN;
        end
      end
      DATA: begin
        if (xfer_s) begin
          // Write is registered, so ram_we appears the cycle after the transfer.
          ram_we_s    = 1'b1;
          ram_addr_s  = cnt_r[ADDR_WIDTH-1:0];
          ram_wdata_s = in_data;
          acc_s       = acc_r + in_data;
          cnt_s       = cnt_r + LEN_W'(1);
          if ((cnt_r + LEN_W'(1)) == len_r) begin
            state_s = CSUM;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      CSUM: begin
        if (xfer_s) begin
          if (in_data == acc_r) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            state_s = ERR;
            error_s = 1'b1;
          end
        end else begin
          state_s = CSUM;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      len_r       <= {LEN_W{1'b0}};
      cnt_r       <= {LEN_W{1'b0}};
      acc_r       <= {DATA_WIDTH{1'b0}};
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {ADDR_WIDTH{1'b0}};
      ram_wdata_r <= {DATA_WIDTH{1'b0}};
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      cpu_hold_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      cnt_r       <= cnt_s;
      acc_r       <= acc_s;
      ram_we_r    <= ram_we_s;
      ram_addr_r  <= ram_addr_s;
      ram_wdata_r <= ram_wdata_s;
      done_r      <= done_s;
      error_r     <= error_s;
      in_ready_r  <= in_session_s;
      busy_r      <= in_session_s;
      cpu_hold_r  <= in_session_s || (state_s == ERR);
    end
  end

  // A write already queued in ram_we_r must not reach the RAM in the cycle
  // reset is asserted, so the strobe is qualified by reset directly.
  assign ram_we    = ram_we_r & ~reset;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign cpu_hold  = cpu_hold_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_fails  = 0;

  // Every RAM write seen, as {addr, data}, one entry per cycle ram_we is high.
  logic [11:0] wlog[$];

  program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we === 1'b1) wlog.push_back({ram_addr, ram_wdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte for exactly one cycle; in_ready must be high when it is sent.
  task automatic send_byte(input logic [7:0] b, input string name);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL %s in_ready: got %b want 1 (byte %h)", name, in_ready, b);
    end
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    n_checks++;
    if ({in_ready, ram_we, ram_addr, ram_wdata, busy, done, error, cpu_hold} !== 18'h0) begin
      n_fails++;
      $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h busy=%b done=%b err=%b hold=%b want all 0",
               in_ready, ram_we, ram_addr, ram_wdata, busy, done, error, cpu_hold);
    end
    // Reset wins over start.
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_priority: got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
    // in_valid in IDLE is ignored.
    in_valid = 1'b1; in_data = 8'h05;
    tick(); tick();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || wlog.size() != 0) begin
      n_fails++;
      $display("FAIL idle_ignore: got busy=%b rdy=%b writes=%0d want 0 0 0", busy, in_ready, wlog.size());
    end
  endtask

  task automatic test_good_load();
    logic [7:0] s[5] = '{8'h03, 8'h0E, 8'h10, 8'hAB, 8'hC9};
    logic [11:0] exp[3] = '{12'h00E, 12'h110, 12'h2AB};
    wlog.delete();
    pulse_start();
    n_checks++;
    if ({busy, in_ready, cpu_hold, done, error} !== 5'b11100) begin
      n_fails++;
      $display("FAIL good_session_open: got busy=%b rdy=%b hold=%b done=%b err=%b want 1 1 1 0 0",
               busy, in_ready, cpu_hold, done, error);
    end
    for (int i = 0; i < 5; i++) send_byte(s[i], "good_b2b");
    tick();
    n_checks++;
    if (wlog.size() != 3) begin
      n_fails++;
      $display("FAIL good_write_count: got %0d want 3", wlog.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wlog[i] !== exp[i]) begin
        n_fails++;
        $display("FAIL good_write%0d: got %h want %h", i, wlog[i], exp[i]);
      end
    end
    n_checks++;
    if ({done, error, cpu_hold, busy, in_ready} !== 5'b10000) begin
      n_fails++;
      $display("FAIL good_status: got done=%b err=%b hold=%b busy=%b rdy=%b want 1 0 0 0 0",
               done, error, cpu_hold, busy, in_ready);
    end
    n_checks++;
    if (ram_we !== 1'b0 || ram_addr !== 4'h2 || ram_wdata !== 8'hAB) begin
      n_fails++;
      $display("FAIL good_hold_bus: got we=%b a=%h d=%h want 0 2 ab", ram_we, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] s[4] = '{8'h02, 8'h11, 8'h22, 8'h34};
    wlog.delete();
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || error !== 1'b0) begin
      n_fails++;
      $display("FAIL start_clears_done: got done=%b err=%b want 0 0", done, error);
    end
    for (int i = 0; i < 4; i++) send_byte(s[i], "badcsum");
    tick();
    n_checks++;
    if (wlog.size() != 2 || wlog[0] !== 12'h011 || wlog[1] !== 12'h122) begin
      n_fails++;
      $display("FAIL badcsum_writes: got n=%0d w0=%h w1=%h want 2 011 122", wlog.size(), wlog[0], wlog[1]);
    end
    n_checks++;
    if ({error, cpu_hold, done, busy} !== 4'b1100) begin
      n_fails++;
      $display("FAIL badcsum_status: got err=%b hold=%b done=%b busy=%b want 1 1 0 0",
               error, cpu_hold, done, busy);
    end
  endtask

  task automatic test_bad_length();
    logic [7:0] lens[2] = '{8'h00, 8'h11};
    wlog.delete();
    for (int i = 0; i < 2; i++) begin
      pulse_start();
      n_checks++;
      if (error !== 1'b0) begin
        n_fails++;
        $display("FAIL badlen%0d_clear: got err=%b want 0", i, error);
      end
      send_byte(lens[i], "badlen");
      tick();
      n_checks++;
      if ({error, done, cpu_hold, busy, in_ready} !== 5'b10100 || wlog.size() != 0) begin
        n_fails++;
        $display("FAIL badlen_%h: got err=%b done=%b hold=%b busy=%b rdy=%b writes=%0d want 1 0 1 0 0 0",
                 lens[i], error, done, cpu_hold, busy, in_ready, wlog.size());
      end
    end
  endtask

  task automatic test_full_depth();
    wlog.delete();
    pulse_start();
    send_byte(8'h10, "full_len");
    for (int i = 0; i < 16; i++) send_byte(8'(i), "full_data");
    send_byte(8'h78, "full_csum");
    tick();
    n_checks++;
    if (wlog.size() != 16) begin
      n_fails++;
      $display("FAIL full_write_count: got %0d want 16", wlog.size());
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (wlog[i] !== {4'(i), 8'(i)}) begin
        n_fails++;
        $display("FAIL full_write%0d: got %h want %h", i, wlog[i], {4'(i), 8'(i)});
      end
    end
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0 || ram_addr !== 4'hF) begin
      n_fails++;
      $display("FAIL full_status: got done=%b err=%b a=%h want 1 0 f", done, error, ram_addr);
    end
  endtask

  task automatic test_gap();
    logic [7:0] s[5] = '{8'h03, 8'h0E, 8'h10, 8'hAB, 8'hC9};
    logic [11:0] exp[3] = '{12'h00E, 12'h110, 12'h2AB};
    wlog.delete();
    pulse_start();
    send_byte(s[0], "gap");
    send_byte(s[1], "gap");
    in_data = 8'h55;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (wlog.size() != 1 || ram_we !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL gap_stall: got writes=%0d we=%b busy=%b rdy=%b want 1 0 1 1",
               wlog.size(), ram_we, busy, in_ready);
    end
    for (int i = 2; i < 5; i++) send_byte(s[i], "gap");
    tick();
    n_checks++;
    if (wlog.size() != 3 || wlog[0] !== exp[0] || wlog[1] !== exp[1] || wlog[2] !== exp[2]) begin
      n_fails++;
      $display("FAIL gap_writes: got n=%0d %h %h %h want 3 00e 110 2ab",
               wlog.size(), wlog[0], wlog[1], wlog[2]);
    end
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      n_fails++;
      $display("FAIL gap_status: got done=%b err=%b want 1 0", done, error);
    end
  endtask

  task automatic test_reset_mid();
    wlog.delete();
    pulse_start();
    send_byte(8'h03, "mid");
    // Start while busy is ignored: the concurrent data byte still goes to index 0.
    start = 1'b1;
    send_byte(8'h0E, "mid");
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'h0) begin
      n_fails++;
      $display("FAIL busy_start_ignored: got busy=%b we=%b a=%h want 1 1 0", busy, ram_we, ram_addr);
    end
    send_byte(8'h10, "mid");
    // Write of 0x10 is pending this cycle; reset must suppress it.
    reset = 1'b1;
    #1;
    n_checks++;
    if (ram_we !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_kills_pending: got we=%b want 0", ram_we);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if ({in_ready, ram_we, ram_addr, ram_wdata, busy, done, error, cpu_hold} !== 18'h0) begin
      n_fails++;
      $display("FAIL mid_reset_outputs: got rdy=%b we=%b a=%h d=%h busy=%b done=%b err=%b hold=%b want all 0",
               in_ready, ram_we, ram_addr, ram_wdata, busy, done, error, cpu_hold);
    end
    tick(); tick();
    n_checks++;
    if (wlog.size() != 1 || wlog[0] !== 12'h00E) begin
      n_fails++;
      $display("FAIL mid_reset_writes: got n=%0d w0=%h want 1 00e", wlog.size(), wlog[0]);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_bad_length();
    test_full_depth();
    test_gap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
